// File: rtl/edge_row_packer.sv
// Packs the serial edge-bit stream into row words, buffers them in a small
// FIFO for the frame writer, and tracks per-frame edge count, completion and overflow.
module edge_row_packer #(
  parameter int ROW_LEN    = 18,
  parameter int NUM_ROWS   = 18,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               edge_in,
  input  logic               edge_valid,
  output logic [ROW_LEN-1:0] row_data,
  output logic [4:0]         row_idx,
  output logic               row_valid,
  input  logic               row_ready,
  output logic [CNT_W-1:0]   edge_count,
  output logic               frame_done,
  output logic               overflow
);

  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int COLW  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int ENT_W = ROW_LEN + 5;

  typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [COLW-1:0]    col_q, col_d;
  logic [4:0]         row_q, row_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               ovf_q, ovf_d;

  logic [ROW_LEN-1:0] shift_q;
  logic [ROW_LEN-1:0] word;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];

  logic accept, push, pop, full, wr_en, drop;

  // Bits are accepted only while collecting; a simultaneous frame_start wins.
  assign accept = (state_q == COLLECT) && edge_valid && !frame_start;
  assign push   = accept && (col_q == COLW'(ROW_LEN - 1));
  assign pop    = row_valid && row_ready;
  assign full   = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign wr_en  = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_comb begin
    word         = shift_q;
    word[col_q]  = edge_in;
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;

    if (frame_start) begin
      state_d    = COLLECT;
      col_d      = '0;
      row_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      edge_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (accept) begin
        if (edge_in && (edge_cnt_q != '1))
          edge_cnt_d = edge_cnt_q + 1'b1;
        if (push) begin
          col_d = '0;
          row_d = (row_q == 5'(NUM_ROWS - 1)) ? 5'd0 : row_q + 5'd1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!wr_en && pop) cnt_d = cnt_q - 1'b1;
      if (drop) ovf_d = 1'b1;

      unique case (state_q)
        COLLECT: if (push && (row_q == 5'(NUM_ROWS - 1))) state_d = DRAIN;
        // No pushes happen here, so emptiness includes a same-cycle final pop.
        DRAIN:   if ((cnt_q == '0) || ((cnt_q == (PW+1)'(1)) && pop)) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= COLLECT;
      col_q      <= '0;
      row_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Datapath storage carries no reset; outputs are gated by row_valid instead.
  always_ff @(posedge clk) begin
    if (accept) shift_q <= word;
    if (wr_en)  mem_q[wr_ptr_q] <= {row_q, word};
  end

  assign row_valid  = (cnt_q != '0);
  assign row_data   = row_valid ? mem_q[rd_ptr_q][ROW_LEN-1:0] : '0;
  assign row_idx    = row_valid ? mem_q[rd_ptr_q][ENT_W-1:ROW_LEN] : 5'd0;
  assign edge_count = edge_cnt_q;
  assign frame_done = (state_q == DONE);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_edge_row_packer.sv
// Directed self-checking bench for edge_row_packer.
module tb_edge_row_packer;

  localparam int ROW_LEN = 18;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        edge_in;
  logic        edge_valid;
  logic [17:0] row_data;
  logic [4:0]  row_idx;
  logic        row_valid;
  logic        row_ready;
  logic [8:0]  edge_count;
  logic        frame_done;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  edge_row_packer #(.ROW_LEN(18), .NUM_ROWS(18), .FIFO_DEPTH(4), .CNT_W(9)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .edge_in(edge_in),
    .edge_valid(edge_valid), .row_data(row_data), .row_idx(row_idx),
    .row_valid(row_valid), .row_ready(row_ready), .edge_count(edge_count),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    edge_valid = 1'b1;
    edge_in    = b;
    tick();
    edge_valid = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    edge_valid  = 1'b0;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_start = 1'b0; edge_in = 1'b0; edge_valid = 1'b0; row_ready = 1'b0;
    #3;
    checks++; if (row_data !== 18'h0) begin errors++; $display("FAIL reset_row_data got %0h exp 0", row_data); end
    checks++; if (row_idx !== 5'd0) begin errors++; $display("FAIL reset_row_idx got %0d exp 0", row_idx); end
    checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL reset_row_valid got %0b exp 0", row_valid); end
    checks++; if (edge_count !== 9'd0) begin errors++; $display("FAIL reset_edge_count got %0d exp 0", edge_count); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0b exp 0", frame_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_one_row();
    start_frame();
    row_ready = 1'b1;
    for (int j = 0; j < ROW_LEN - 1; j++) send_bit(1'b1);
    checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL one_row_early_valid got %0b exp 0", row_valid); end
    send_bit(1'b1);
    checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL one_row_valid got %0b exp 1", row_valid); end
    checks++; if (row_data !== 18'h3FFFF) begin errors++; $display("FAIL one_row_data got %0h exp 3ffff", row_data); end
    checks++; if (row_idx !== 5'd0) begin errors++; $display("FAIL one_row_idx got %0d exp 0", row_idx); end
    checks++; if (edge_count !== 9'd18) begin errors++; $display("FAIL one_row_count got %0d exp 18", edge_count); end
    tick();
    checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL one_row_popped got %0b exp 0", row_valid); end
  endtask

  task automatic test_alt_gaps();
    int sent;
    int c;
    start_frame();
    row_ready = 1'b0;
    sent = 0;
    c = 0;
    while (sent < ROW_LEN) begin
      if (c % 3 == 2) begin
        edge_valid = 1'b0;
        edge_in    = 1'b1;
        tick();
      end else begin
        if (sent == ROW_LEN - 1) begin
          checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL alt_early_valid got %0b exp 0", row_valid); end
        end
        send_bit((sent % 2) == 0);
        sent++;
      end
      c++;
    end
    checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL alt_valid got %0b exp 1", row_valid); end
    checks++; if (row_data !== 18'h15555) begin errors++; $display("FAIL alt_data got %0h exp 15555", row_data); end
    checks++; if (edge_count !== 9'd9) begin errors++; $display("FAIL alt_count got %0d exp 9", edge_count); end
    tick();
    checks++; if (row_data !== 18'h15555) begin errors++; $display("FAIL alt_hold got %0h exp 15555", row_data); end
    row_ready = 1'b1;
    tick();
    row_ready = 1'b0;
  endtask

  task automatic test_overflow();
    start_frame();
    row_ready = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < ROW_LEN; j++) send_bit(1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before got %0b exp 0", overflow); end
    for (int j = 0; j < ROW_LEN; j++) send_bit(1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", overflow); end
    row_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 5'(i)) begin
        errors++; $display("FAIL ovf_pop%0d got valid=%0b idx=%0d exp valid=1 idx=%0d", i, row_valid, row_idx, i);
      end
      tick();
    end
    checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0b exp 0", row_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
    row_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    start_frame();
    row_ready = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < ROW_LEN; j++) send_bit(1'b0);
    for (int j = 0; j < ROW_LEN - 1; j++) send_bit(1'b1);
    row_ready = 1'b1;
    send_bit(1'b1);
    row_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %0b exp 0", overflow); end
    row_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 5'(i)) begin
        errors++; $display("FAIL fullpop_pop%0d got valid=%0b idx=%0d exp valid=1 idx=%0d", i, row_valid, row_idx, i);
      end
      if (i == 4) begin
        checks++; if (row_data !== 18'h3FFFF) begin errors++; $display("FAIL fullpop_data got %0h exp 3ffff", row_data); end
      end
      tick();
    end
    checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %0b exp 0", row_valid); end
    row_ready = 1'b0;
  endtask

  task automatic test_full_frame();
    logic [17:0] exp;
    start_frame();
    row_ready = 1'b1;
    for (int r = 0; r < 18; r++) begin
      for (int j = 0; j < ROW_LEN; j++) begin
        exp[j] = ((r * ROW_LEN + j) < 100);
        send_bit(exp[j]);
      end
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 5'(r) || row_data !== exp) begin
        errors++;
        $display("FAIL frame_row%0d got valid=%0b idx=%0d data=%0h exp valid=1 idx=%0d data=%0h",
                 r, row_valid, row_idx, row_data, r, exp);
      end
    end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_early got %0b exp 0", frame_done); end
    checks++; if (edge_count !== 9'd100) begin errors++; $display("FAIL frame_count got %0d exp 100", edge_count); end
    tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done got %0b exp 1", frame_done); end
    checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL frame_drained got %0b exp 0", row_valid); end
    for (int k = 0; k < ROW_LEN + 2; k++) send_bit(1'b1);
    checks++; if (edge_count !== 9'd100) begin errors++; $display("FAIL frame_ignore_count got %0d exp 100", edge_count); end
    checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL frame_ignore_valid got %0b exp 0", row_valid); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done_hold got %0b exp 1", frame_done); end
    start_frame();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_clear_done got %0b exp 0", frame_done); end
    checks++; if (edge_count !== 9'd0) begin errors++; $display("FAIL frame_clear_count got %0d exp 0", edge_count); end
    row_ready = 1'b0;
  endtask

  task automatic test_reset_mid_row();
    start_frame();
    row_ready = 1'b0;
    for (int k = 0; k < 2 * ROW_LEN + 7; k++) send_bit(1'b1);
    checks++; if (edge_count !== 9'd43) begin errors++; $display("FAIL mid_count_before got %0d exp 43", edge_count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b exp 0", row_valid); end
    checks++; if (row_data !== 18'h0 || row_idx !== 5'd0) begin errors++; $display("FAIL mid_head got data=%0h idx=%0d exp 0 0", row_data, row_idx); end
    checks++; if (edge_count !== 9'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", edge_count); end
    checks++; if (overflow !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL mid_flags got ovf=%0b done=%0b exp 0 0", overflow, frame_done); end
    tick();
    reset = 1'b0;
    tick();
    start_frame();
    for (int j = 0; j < ROW_LEN; j++) send_bit(1'b1);
    checks++;
    if (row_valid !== 1'b1 || row_idx !== 5'd0 || row_data !== 18'h3FFFF) begin
      errors++; $display("FAIL mid_new_row got valid=%0b idx=%0d data=%0h exp 1 0 3ffff", row_valid, row_idx, row_data);
    end
    checks++; if (edge_count !== 9'd18) begin errors++; $display("FAIL mid_new_count got %0d exp 18", edge_count); end
  endtask

  initial begin
    test_reset();
    test_one_row();
    test_alt_gaps();
    test_overflow();
    test_full_pop();
    test_full_frame();
    test_reset_mid_row();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
